multi_edge_monitor: RTL

MULTI_EDGE_MONITOR -- requirements
Module: multi_edge_monitor

---
 rtl/multi_edge_monitor.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/multi_edge_monitor.sv
//==============================================================================
// Module      : multi_edge_monitor
// Description : Multi-channel asynchronous edge monitor. Each raw input is
//               synchronised, glitch filtered, and edge classified against a
//               per-channel mode. Qualifying edges produce a one-cycle pulse,
//               set a sticky flag and (optionally) bump a saturating counter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports
//   iClk      in   1           rising-edge clock
//   iRst_n    in   1           asynchronous active-low reset (release is
//                              synchronised internally)
//   iClear    in   1           synchronous re-seed of filters, clear of state
//   iClrMask  in   NUM_CH      per-channel sticky/counter clear
//   iMode     in   2*NUM_CH    edge select per channel: 00 off, 01 rise,
//                              10 fall, 11 both
//   iSig      in   NUM_CH      asynchronous raw inputs
//   oFilt     out  NUM_CH      filtered level
//   oPulse    out  NUM_CH      one-cycle pulse per qualifying edge
//   oPrev     out  NUM_CH      filtered level before last accepted change
//   oSticky   out  NUM_CH      latched qualifying-edge flag
//   oIrq      out  1           registered OR of oSticky
//   oEvtCnt   out  NUM_CH*CNT_W  saturating event counts, ch n at [n*CNT_W +: CNT_W]
//
// Configuration macro
//   MULTI_EDGE_MONITOR_EVT_CNT_EN : when defined, the per-channel event
//   counters are built; otherwise oEvtCnt is tied to zero.
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module multi_edge_monitor #(
    parameter int                NUM_CH      = 8,
    parameter int                SYNC_STAGES = 2,
    parameter int                FILT_CYC    = 4,
    parameter logic [NUM_CH-1:0] INIT_LVL    = '0,
    parameter int                CNT_W       = 8
) (
    input  logic                    iClk,
    input  logic                    iRst_n,
    input  logic                    iClear,
    input  logic [NUM_CH-1:0]       iClrMask,
    input  logic [2*NUM_CH-1:0]     iMode,
    input  logic [NUM_CH-1:0]       iSig,
    output logic [NUM_CH-1:0]       oFilt,
    output logic [NUM_CH-1:0]       oPulse,
    output logic [NUM_CH-1:0]       oPrev,
    output logic [NUM_CH-1:0]       oSticky,
    output logic                    oIrq,
    output logic [NUM_CH*CNT_W-1:0] oEvtCnt
);

    localparam logic [7:0] c_FILT_CYC = 8'(FILT_CYC);

    // Reset: asserts asynchronously, releases on a clock edge so every
    // channel leaves reset together.
    logic [1:0] r_rst_pipe;
    logic       w_rst_n;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_rst_pipe <= 2'b00;
        end else begin
            r_rst_pipe <= {r_rst_pipe[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_pipe[1];

    logic [SYNC_STAGES-1:0][NUM_CH-1:0] r_sync;
    logic [NUM_CH-1:0]                  w_sync;
    logic [NUM_CH-1:0][7:0]             r_fcnt;
    logic [NUM_CH-1:0][7:0]             w_fcnt_nxt;
    logic [NUM_CH-1:0]                  r_filt;
    logic [NUM_CH-1:0]                  r_pulse;
    logic [NUM_CH-1:0]                  r_prev;
    logic [NUM_CH-1:0]                  r_sticky;
    logic                               r_irq;
    logic [NUM_CH-1:0]                  w_accept;
    logic [NUM_CH-1:0]                  w_qual;

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Filter: count while the synchronised level disagrees with oFilt; the
    // change is accepted on the cycle the count already equals FILT_CYC,
    // which gives FILT_CYC=0 a plain one-cycle delay.
    always_comb begin
        for (int n = 0; n < NUM_CH; n++) begin
            w_accept[n]   = 1'b0;
            w_fcnt_nxt[n] = 8'd0;
            if (w_sync[n] != r_filt[n]) begin
                if (r_fcnt[n] == c_FILT_CYC) begin
                    w_accept[n] = 1'b1;
                end else begin
                    w_fcnt_nxt[n] = r_fcnt[n] + 8'd1;
                end
            end
            // Mode bit 0 enables rising edges, bit 1 falling edges.
            w_qual[n] = w_accept[n] & (w_sync[n] ? iMode[2*n] : iMode[2*n+1]);
        end
    end

    always_ff @(posedge iClk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sync   <= {SYNC_STAGES{INIT_LVL}};
            r_filt   <= INIT_LVL;
            r_fcnt   <= '0;
            r_pulse  <= '0;
            r_prev   <= '0;
            r_sticky <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], iSig};
            r_irq  <= |r_sticky;
            if (iClear) begin
                r_filt   <= w_sync;
                r_fcnt   <= '0;
                r_pulse  <= '0;
                r_prev   <= '0;
                r_sticky <= '0;
            end else begin
                r_fcnt   <= w_fcnt_nxt;
                r_filt   <= (r_filt & ~w_accept) | (w_sync & w_accept);
                r_pulse  <= w_qual;
                r_prev   <= (r_prev & ~w_accept) | (r_filt & w_accept);
                // A same-cycle edge wins over the per-channel clear.
                r_sticky <= (r_sticky & ~iClrMask) | w_qual;
            end
        end
    end

`ifdef MULTI_EDGE_MONITOR_EVT_CNT_EN
    logic [NUM_CH-1:0][CNT_W-1:0] r_evt;

    always_ff @(posedge iClk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_evt <= '0;
        end else if (iClear) begin
            r_evt <= '0;
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (iClrMask[n]) begin
                    r_evt[n] <= CNT_W'(w_qual[n]);
                end else if (w_qual[n] && (r_evt[n] != {CNT_W{1'b1}})) begin
                    r_evt[n] <= r_evt[n] + CNT_W'(1);
                end
            end
        end
    end

    assign oEvtCnt = r_evt;
`else
    assign oEvtCnt = '0;
`endif

    assign oFilt   = r_filt;
    assign oPulse  = r_pulse;
    assign oPrev   = r_prev;
    assign oSticky = r_sticky;
    assign oIrq    = r_irq;

endmodule

`default_nettype wire
